// File: rtl/iob_axistream_in.sv
// rtl/iob_axistream_in.sv - AXI4-Stream byte receiver packing into a CPU-polled word FIFO
module iob_axistream_in #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 2,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    input  logic [7:0]        tdata,
    input  logic              tvalid,
    output logic              tready,
    input  logic              tlast
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [34:0]                mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]           level_q, level_d;
    logic [1:0]                 byte_cnt_q, byte_cnt_d;
    logic [31:0]                word_q, word_d;
    logic                       overrun_q, overrun_d;
    logic                       tready_q, tready_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic                       ready_q;

    logic        full, empty, rd_req, wr_req, ctrl_wr, flush, clr_ov;
    logic        pop, accept, push;
    logic [31:0] word_ins;
    logic [34:0] head, entry;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[DATA_W-1:2];

    always_comb begin
        full     = (level_q == LVL_FULL);
        empty    = (level_q == '0);
        head     = mem_q[rd_ptr_q];
        rd_req   = valid & ~(|wstrb);
        wr_req   = valid & (|wstrb);
        ctrl_wr  = wr_req & (address == ADDR_W'(3));
        flush    = ctrl_wr & wdata[0];
        clr_ov   = ctrl_wr & wdata[1];
        pop      = rd_req & (address == ADDR_W'(0)) & ~empty;
        accept   = tvalid & tready_q;
        word_ins = word_q | ({24'b0, tdata} << {byte_cnt_q, 3'b000});
        push     = accept & ((byte_cnt_q == 2'd3) | tlast);
        entry    = {tlast, byte_cnt_q, word_ins};

        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        if (flush || push) begin
            byte_cnt_d = 2'd0;
            word_d     = 32'd0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_d     = word_ins;
        end

        // flush dominates any push or pop landing in the same cycle
        if (flush) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(push);
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(pop);
        end

        tready_d  = (level_d != LVL_FULL);
        overrun_d = (overrun_q & ~clr_ov) | (tvalid & ~tready_q & tlast);

        rdata_d = '0;
        if (rd_req) begin
            if (address == ADDR_W'(0)) begin
                rdata_d = empty ? '0 : DATA_W'(head[31:0]);
            end else if (address == ADDR_W'(1)) begin
                rdata_d = DATA_W'({full, empty,
                                   empty ? 1'b0 : head[34],
                                   empty ? 2'b00 : head[33:32],
                                   overrun_q});
            end else if (address == ADDR_W'(2)) begin
                rdata_d = DATA_W'(level_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            overrun_q  <= 1'b0;
            tready_q   <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            overrun_q  <= overrun_d;
            tready_q   <= tready_d;
            rdata_q    <= rdata_d;
            ready_q    <= valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !flush) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign rdata  = rdata_q;
    assign ready  = ready_q;
    assign tready = tready_q;
endmodule

// File: tb/tb_iob_axistream_in.sv
// tb/tb_iob_axistream_in.sv - scoreboard bench for iob_axistream_in against a queue-based model
module tb_iob_axistream_in;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    iob_axistream_in #(.DATA_W(32), .ADDR_W(2), .FIFO_DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .tdata(tdata),
        .tvalid(tvalid), .tready(tready), .tlast(tlast)
    );

    always #5 clk = ~clk;

    typedef struct { bit chk; logic [31:0] val; int addr; } exp_t;
    typedef struct { bit last; int nbm1; logic [31:0] word; } ent_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       expq[$];
    ent_t       mfifo[$];
    logic [7:0] pend[$];
    bit         ov_m = 0;
    exp_t       mon_e;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(int addr);
        bit e;
        e = (mfifo.size() == 0);
        case (addr)
            0: return e ? 32'd0 : mfifo[0].word;
            1: return {26'd0, mfifo.size() == 16, e,
                       e ? 1'b0 : mfifo[0].last,
                       e ? 2'd0 : 2'(mfifo[0].nbm1), ov_m};
            2: return 32'(mfifo.size());
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready: got ready=1 required no outstanding request");
            end else begin
                mon_e = expq.pop_front();
                if (mon_e.chk) chk($sformatf("rdata_addr%0d", mon_e.addr), rdata, mon_e.val);
            end
        end
    end

    // One clock of stimulus; req: 0 none, 1 read, 2 write
    task automatic cyc(bit db, logic [7:0] b, bit l, int req, int addr, logic [31:0] wd);
        exp_t e;
        bit   tr, fl;
        logic [31:0] w;
        @(negedge clk);
        tr = (mfifo.size() != 16);
        chk("tready", {31'd0, tready}, {31'd0, tr});
        valid   = (req != 0);
        address = 2'(addr);
        wstrb   = (req == 2) ? 4'hF : 4'h0;
        wdata   = wd;
        tvalid  = db;
        tdata   = b;
        tlast   = l;
        if (req != 0) begin
            e.chk  = (req == 1);
            e.val  = model_read(addr);
            e.addr = addr;
            expq.push_back(e);
        end
        fl = 0;
        if (req == 2 && addr == 3) begin
            fl = wd[0];
            if (wd[1]) ov_m = 0;
        end
        if (db && l && !tr) ov_m = 1;
        if (req == 1 && addr == 0 && mfifo.size() > 0) void'(mfifo.pop_front());
        if (fl) begin
            mfifo.delete();
            pend.delete();
        end else if (db && tr) begin
            pend.push_back(b);
            if (pend.size() == 4 || l) begin
                w = 0;
                foreach (pend[i]) w = w + (32'(pend[i]) << (8 * i));
                mfifo.push_back('{last: l, nbm1: pend.size() - 1, word: w});
                pend.delete();
            end
        end
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 0, 0, 32'd0);
    endtask

    task automatic rd(int a);
        cyc(0, 8'h00, 0, 1, a, 32'd0);
    endtask

    task automatic ctrl(logic [31:0] v);
        cyc(0, 8'h00, 0, 2, 3, v);
    endtask

    task automatic send(logic [7:0] b, bit l);
        cyc(1, b, l, 0, 0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        valid  = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_tready", {31'd0, tready}, 32'd0);
        mfifo.delete();
        pend.delete();
        ov_m = 0;
        rst  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; valid = 0; address = 0; wdata = 0; wstrb = 0;
        tdata = 0; tvalid = 0; tlast = 0;
        do_reset();

        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        rd(1); rd(2); rd(0); rd(2);

        send(8'hAA, 0); send(8'hBB, 1);
        rd(1); rd(0);

        rd(0); rd(2); rd(3);

        // fill to full without pops, then stall a packet end
        n = 0;
        while (mfifo.size() < 16 && n < 200) begin
            send(8'($urandom), 0);
            n++;
        end
        chk("fill_entries", 32'(mfifo.size()), 32'd16);
        send(8'h5A, 1);
        send(8'h5B, 0);
        rd(1); rd(2);
        for (int i = 0; i < 16; i++) rd(0);
        idle();
        rd(1);
        ctrl(32'd2);
        rd(1);

        // simultaneous push and pop at level 5
        for (int i = 0; i < 20; i++) send(8'($urandom), 0);
        rd(2);
        cyc(1, 8'h77, 1, 1, 0, 32'd0);
        rd(2);
        for (int i = 0; i < 5; i++) rd(0);
        rd(2);

        // partial packet discarded by flush, then by reset
        send(8'hC1, 0); send(8'hC2, 0);
        ctrl(32'd1);
        rd(2);
        send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 0);
        rd(1); rd(0);
        send(8'hE1, 0); send(8'hE2, 0);
        idle(); idle();
        do_reset();
        rd(2);
        send(8'hF1, 0); send(8'hF2, 0); send(8'hF3, 0); send(8'hF4, 0);
        rd(0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 10) < 6, 8'($urandom), ($urandom % 8) == 0,
                (($urandom % 10) < 4) ? 1 : 0, int'($urandom % 4), 32'd0);
        end
        while (mfifo.size() > 0 && n < 400) begin
            rd(0);
            n++;
        end
        rd(2);
        idle(); idle(); idle();
        chk("outstanding_responses", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
